sa_dma_sequencer: RTL and testbench

Parametrised successor to the fixed-count DMA block controller that sits between the systolic-array core and the dma_read/dma_write engines.
- Burst length, per-channel read block counts, write block count and base addresses are all programmed at run time; nothing is hard-coded.
- Supports NUM_RD_CH independent read regions (e.g. operand A, operand B), each with its own base address and block count.
- Adds parameter checking, a per-burst watchdog, abort, and an error code.

---
 rtl/sa_dma_sequencer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_sa_dma_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_dma_sequencer.sv
// sa_dma_sequencer: run-time programmable block sequencer between the
// systolic-array core and the dma_read / dma_write engines.
//   clk, rst            : clock, synchronous active-high reset
//   i_start, i_abort    : run control; config i_* sampled with i_start
//   i_rd_base/i_rd_blks : per-read-channel base address / block count
//   i_wr_base/i_wr_blks : write base address / block count
//   i_num_trans         : beats per burst
//   i_req_rd/i_req_wr   : core batch requests (sampled in HOLD)
//   o_ctrl_read/write   : one-cycle DMA start pulses with address
//   i_read/write_done   : DMA completion
//   o_core_rd/wr_done   : one-cycle batch-complete pulses to the core
//   o_busy/o_done/o_error/o_err_code : run status
module sa_dma_sequencer #(
  parameter int unsigned AXI_WIDTH_AD   = 32,
  parameter int unsigned BIT_TRANS      = 8,
  parameter int unsigned NUM_RD_CH      = 2,
  parameter int unsigned BLK_W          = 16,
  parameter int unsigned BYTES_PER_BEAT = 4,
  parameter int unsigned TIMEOUT_CYC    = 4096,
  localparam int unsigned CH_W = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [NUM_RD_CH*AXI_WIDTH_AD-1:0] i_rd_base,
  input  logic [AXI_WIDTH_AD-1:0]           i_wr_base,
  input  logic [BIT_TRANS-1:0]              i_num_trans,
  input  logic [NUM_RD_CH*BLK_W-1:0]        i_rd_blks,
  input  logic [BLK_W-1:0]                  i_wr_blks,
  input  logic                              i_req_rd,
  input  logic                              i_req_wr,
  output logic                              o_core_rd_done,
  output logic                              o_core_wr_done,
  output logic                              o_ctrl_read,
  output logic [AXI_WIDTH_AD-1:0]           o_read_addr,
  output logic [CH_W-1:0]                   o_rd_ch,
  input  logic                              i_read_done,
  output logic                              o_ctrl_write,
  output logic [AXI_WIDTH_AD-1:0]           o_write_addr,
  input  logic                              i_write_done,
  output logic [BIT_TRANS-1:0]              o_num_trans,
  output logic [BLK_W-1:0]                  o_blk_idx,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_error,
  output logic [1:0]                        o_err_code
);

  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit          WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CFG     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CHECK, ST_HOLD, ST_RD_ISSUE, ST_RD_WAIT,
    ST_WR_ISSUE, ST_WR_WAIT, ST_DONE, ST_ERR
  } state_t;

  state_t state_q, state_d;

  // latched run configuration
  logic [BIT_TRANS-1:0]    num_trans_q;
  logic [AXI_WIDTH_AD-1:0] rd_base_q [NUM_RD_CH];
  logic [BLK_W-1:0]        rd_blks_q [NUM_RD_CH];
  logic [AXI_WIDTH_AD-1:0] wr_base_q;
  logic [BLK_W-1:0]        wr_blks_q;

  // registered datapath / outputs
  logic [CH_W-1:0]         rd_ch_q, rd_ch_d;
  logic [BLK_W-1:0]        blk_idx_q, blk_idx_d;
  logic [AXI_WIDTH_AD-1:0] rd_addr_q, rd_addr_d;
  logic [AXI_WIDTH_AD-1:0] wr_addr_q, wr_addr_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic ctrl_read_q, ctrl_read_d, ctrl_write_q, ctrl_write_d;
  logic core_rd_done_q, core_rd_done_d, core_wr_done_q, core_wr_done_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0] err_code_q, err_code_d;

  logic                    start_accept;
  logic [AXI_WIDTH_AD-1:0] stride;
  logic                    first_ok, next_ok;
  logic [CH_W-1:0]         first_ch, next_ch;

  assign stride = AXI_WIDTH_AD'(num_trans_q) * AXI_WIDTH_AD'(BYTES_PER_BEAT);

  // lowest nonzero channel overall, and lowest nonzero channel above the current one
  always_comb begin
    first_ok = 1'b0;
    first_ch = '0;
    next_ok  = 1'b0;
    next_ch  = '0;
    for (int c = int'(NUM_RD_CH) - 1; c >= 0; c--) begin
      if (rd_blks_q[c] != '0) begin
        first_ok = 1'b1;
        first_ch = CH_W'(c);
        if (c > int'(rd_ch_q)) begin
          next_ok = 1'b1;
          next_ch = CH_W'(c);
        end
      end
    end
  end

  // next-state and registered-output values
  always_comb begin
    state_d        = state_q;
    rd_ch_d        = rd_ch_q;
    blk_idx_d      = blk_idx_q;
    rd_addr_d      = rd_addr_q;
    wr_addr_d      = wr_addr_q;
    wd_d           = wd_q;
    ctrl_read_d    = 1'b0;
    ctrl_write_d   = 1'b0;
    core_rd_done_d = 1'b0;
    core_wr_done_d = 1'b0;
    busy_d         = busy_q;
    done_d         = done_q;
    error_d        = error_q;
    err_code_d     = err_code_q;
    start_accept   = 1'b0;

    if (i_abort && !(state_q inside {ST_IDLE, ST_DONE, ST_ERR})) begin
      state_d    = ST_ERR;
      busy_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = ERR_ABORT;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_start) begin
            start_accept = 1'b1;
            state_d      = ST_CHECK;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            error_d      = 1'b0;
            err_code_d   = ERR_NONE;
          end
        end
        ST_CHECK: begin
          if (num_trans_q == '0 || wr_blks_q == '0 || !first_ok) begin
            state_d    = ST_ERR;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_CFG;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // read wins when both requests are present
          if (i_req_rd) begin
            state_d     = ST_RD_ISSUE;
            ctrl_read_d = 1'b1;
            rd_ch_d     = first_ch;
            blk_idx_d   = '0;
            rd_addr_d   = rd_base_q[first_ch];
          end else if (i_req_wr) begin
            state_d      = ST_WR_ISSUE;
            ctrl_write_d = 1'b1;
            blk_idx_d    = '0;
            wr_addr_d    = wr_base_q;
          end
        end
        ST_RD_ISSUE: begin
          state_d = ST_RD_WAIT;
          wd_d    = WD_W'(1);
        end
        ST_RD_WAIT: begin
          if (i_read_done) begin
            if (blk_idx_q != rd_blks_q[rd_ch_q] - BLK_W'(1)) begin
              state_d     = ST_RD_ISSUE;
              ctrl_read_d = 1'b1;
              blk_idx_d   = blk_idx_q + BLK_W'(1);
              rd_addr_d   = rd_addr_q + stride;
            end else if (next_ok) begin
              state_d     = ST_RD_ISSUE;
              ctrl_read_d = 1'b1;
              rd_ch_d     = next_ch;
              blk_idx_d   = '0;
              rd_addr_d   = rd_base_q[next_ch];
            end else begin
              state_d        = ST_HOLD;
              core_rd_done_d = 1'b1;
            end
          end else if (WD_EN && wd_q >= WD_LAST) begin
            state_d    = ST_ERR;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else if (WD_EN) begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        ST_WR_ISSUE: begin
          state_d = ST_WR_WAIT;
          wd_d    = WD_W'(1);
        end
        ST_WR_WAIT: begin
          if (i_write_done) begin
            if (blk_idx_q != wr_blks_q - BLK_W'(1)) begin
              state_d      = ST_WR_ISSUE;
              ctrl_write_d = 1'b1;
              blk_idx_d    = blk_idx_q + BLK_W'(1);
              wr_addr_d    = wr_addr_q + stride;
            end else begin
              state_d        = ST_DONE;
              core_wr_done_d = 1'b1;
              busy_d         = 1'b0;
              done_d         = 1'b1;
            end
          end else if (WD_EN && wd_q >= WD_LAST) begin
            state_d    = ST_ERR;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else if (WD_EN) begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state, output and config registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rd_ch_q        <= '0;
      blk_idx_q      <= '0;
      rd_addr_q      <= '0;
      wr_addr_q      <= '0;
      wd_q           <= '0;
      ctrl_read_q    <= 1'b0;
      ctrl_write_q   <= 1'b0;
      core_rd_done_q <= 1'b0;
      core_wr_done_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
      num_trans_q    <= '0;
      wr_base_q      <= '0;
      wr_blks_q      <= '0;
      for (int c = 0; c < int'(NUM_RD_CH); c++) begin
        rd_base_q[c] <= '0;
        rd_blks_q[c] <= '0;
      end
    end else begin
      state_q        <= state_d;
      rd_ch_q        <= rd_ch_d;
      blk_idx_q      <= blk_idx_d;
      rd_addr_q      <= rd_addr_d;
      wr_addr_q      <= wr_addr_d;
      wd_q           <= wd_d;
      ctrl_read_q    <= ctrl_read_d;
      ctrl_write_q   <= ctrl_write_d;
      core_rd_done_q <= core_rd_done_d;
      core_wr_done_q <= core_wr_done_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      if (start_accept) begin
        num_trans_q <= i_num_trans;
        wr_base_q   <= i_wr_base;
        wr_blks_q   <= i_wr_blks;
        for (int c = 0; c < int'(NUM_RD_CH); c++) begin
          rd_base_q[c] <= i_rd_base[c*AXI_WIDTH_AD +: AXI_WIDTH_AD];
          rd_blks_q[c] <= i_rd_blks[c*BLK_W +: BLK_W];
        end
      end
    end
  end

  assign o_core_rd_done = core_rd_done_q;
  assign o_core_wr_done = core_wr_done_q;
  assign o_ctrl_read    = ctrl_read_q;
  assign o_read_addr    = rd_addr_q;
  assign o_rd_ch        = rd_ch_q;
  assign o_ctrl_write   = ctrl_write_q;
  assign o_write_addr   = wr_addr_q;
  assign o_num_trans    = num_trans_q;
  assign o_blk_idx      = blk_idx_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_err_code     = err_code_q;

endmodule

// File: tb/tb_sa_dma_sequencer.sv
// Directed bench for sa_dma_sequencer: DMA engines modelled by a fixed-latency
// responder, bursts logged per cycle and compared against hand-computed tables.
module tb_sa_dma_sequencer;

  localparam int unsigned AW      = 32;
  localparam int unsigned BT      = 8;
  localparam int unsigned NCH     = 2;
  localparam int unsigned BW      = 16;
  localparam int unsigned TO      = 8;
  localparam int          DMA_LAT = 5;
  localparam int          BUDGET  = 400;

  logic              clk;
  logic              rst;
  logic              i_start, i_abort;
  logic [NCH*AW-1:0] i_rd_base;
  logic [AW-1:0]     i_wr_base;
  logic [BT-1:0]     i_num_trans;
  logic [NCH*BW-1:0] i_rd_blks;
  logic [BW-1:0]     i_wr_blks;
  logic              i_req_rd, i_req_wr;
  logic              o_core_rd_done, o_core_wr_done;
  logic              o_ctrl_read, o_ctrl_write;
  logic [AW-1:0]     o_read_addr, o_write_addr;
  logic [0:0]        o_rd_ch;
  logic              i_read_done, i_write_done;
  logic [BT-1:0]     o_num_trans;
  logic [BW-1:0]     o_blk_idx;
  logic              o_busy, o_done, o_error;
  logic [1:0]        o_err_code;

  sa_dma_sequencer #(
    .AXI_WIDTH_AD(AW), .BIT_TRANS(BT), .NUM_RD_CH(NCH), .BLK_W(BW),
    .BYTES_PER_BEAT(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_rd_base(i_rd_base), .i_wr_base(i_wr_base), .i_num_trans(i_num_trans),
    .i_rd_blks(i_rd_blks), .i_wr_blks(i_wr_blks),
    .i_req_rd(i_req_rd), .i_req_wr(i_req_wr),
    .o_core_rd_done(o_core_rd_done), .o_core_wr_done(o_core_wr_done),
    .o_ctrl_read(o_ctrl_read), .o_read_addr(o_read_addr), .o_rd_ch(o_rd_ch),
    .i_read_done(i_read_done), .o_ctrl_write(o_ctrl_write),
    .o_write_addr(o_write_addr), .i_write_done(i_write_done),
    .o_num_trans(o_num_trans), .o_blk_idx(o_blk_idx), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rd_addr_log [$];
  logic [0:0]  rd_ch_log [$];
  logic [31:0] wr_addr_log [$];
  int          n_rd_done, n_wr_done, n_both;
  int          rd_cnt, wr_cnt;
  bit          auto_en;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: DMA responder first, then log what the DUT shows this cycle
  task automatic tick();
    @(posedge clk);
    #1;
    i_read_done  = 1'b0;
    i_write_done = 1'b0;
    if (rd_cnt > 0) begin rd_cnt--; if (rd_cnt == 0) i_read_done = 1'b1; end
    if (wr_cnt > 0) begin wr_cnt--; if (wr_cnt == 0) i_write_done = 1'b1; end
    if (o_ctrl_read) begin
      rd_addr_log.push_back(o_read_addr);
      rd_ch_log.push_back(o_rd_ch);
      if (auto_en) rd_cnt = DMA_LAT;
    end
    if (o_ctrl_write) begin
      wr_addr_log.push_back(o_write_addr);
      if (auto_en) wr_cnt = DMA_LAT;
    end
    if (o_core_rd_done) n_rd_done++;
    if (o_core_wr_done) n_wr_done++;
    if (o_ctrl_read && o_ctrl_write) n_both++;
  endtask

  task automatic clear_logs();
    rd_addr_log.delete();
    rd_ch_log.delete();
    wr_addr_log.delete();
    n_rd_done = 0;
    n_wr_done = 0;
  endtask

  // returns in the CHECK cycle
  task automatic start_run(input logic [7:0] nt, input logic [31:0] rb0, input logic [31:0] rb1,
                           input logic [15:0] rk0, input logic [15:0] rk1,
                           input logic [31:0] wb, input logic [15:0] wk);
    i_num_trans = nt;
    i_rd_base   = {rb1, rb0};
    i_rd_blks   = {rk1, rk0};
    i_wr_base   = wb;
    i_wr_blks   = wk;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic req_rd();
    i_req_rd = 1'b1;
    tick();
    i_req_rd = 1'b0;
  endtask

  task automatic req_wr();
    i_req_wr = 1'b1;
    tick();
    i_req_wr = 1'b0;
  endtask

  task automatic wait_rd_done(input int target, input string tag);
    int n = 0;
    while (n_rd_done < target && n < BUDGET) begin tick(); n++; end
    check_eq(tag, 64'(n_rd_done), 64'(target));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && !o_error && n < BUDGET) begin tick(); n++; end
    check_eq(tag, 64'(o_done), 64'd1);
  endtask

  function automatic logic [31:0] rd_at(input int i);
    return (i < rd_addr_log.size()) ? rd_addr_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wr_at(input int i);
    return (i < wr_addr_log.size()) ? wr_addr_log[i] : 32'hDEAD_BEEF;
  endfunction

  // base configuration: two read channels of two blocks, four write blocks
  task automatic run_base(input string pre);
    logic [31:0] exp_rd [4] = '{32'h1000, 32'h1040, 32'h2000, 32'h2040};
    logic [0:0]  exp_ch [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_wr [4] = '{32'h3000, 32'h3040, 32'h3080, 32'h30C0};
    clear_logs();
    start_run(8'd16, 32'h1000, 32'h2000, 16'd2, 16'd2, 32'h3000, 16'd4);
    check_eq({pre, "_busy"}, 64'(o_busy), 64'd1);
    tick();
    req_rd();
    wait_rd_done(1, {pre, "_rd_batch"});
    req_wr();
    wait_done({pre, "_run_done"});
    check_eq({pre, "_rd_cnt"}, 64'(rd_addr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_rd_addr%0d", pre, i), 64'(rd_at(i)), 64'(exp_rd[i]));
      check_eq($sformatf("%s_rd_ch%0d", pre, i),
               64'((i < rd_ch_log.size()) ? rd_ch_log[i] : 1'bx), 64'(exp_ch[i]));
      check_eq($sformatf("%s_wr_addr%0d", pre, i), 64'(wr_at(i)), 64'(exp_wr[i]));
    end
    check_eq({pre, "_wr_cnt"}, 64'(wr_addr_log.size()), 64'd4);
    check_eq({pre, "_busy_end"}, 64'(o_busy), 64'd0);
    check_eq({pre, "_num_trans"}, 64'(o_num_trans), 64'd16);
    tick();
    check_eq({pre, "_core_rd_pulses"}, 64'(n_rd_done), 64'd1);
    check_eq({pre, "_core_wr_pulses"}, 64'(n_wr_done), 64'd1);
    check_eq({pre, "_done_sticky"}, 64'(o_done), 64'd1);
    check_eq({pre, "_no_error"}, 64'(o_error), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_req_rd = 1'b0; i_req_wr = 1'b0;
    i_read_done = 1'b0; i_write_done = 1'b0;
    i_rd_base = '0; i_wr_base = '0; i_num_trans = '0; i_rd_blks = '0; i_wr_blks = '0;
    rd_cnt = 0; wr_cnt = 0; n_both = 0; auto_en = 1'b1;
    clear_logs();
    tick();
    tick();
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_done", 64'(o_done), 64'd0);
    check_eq("rst_err_code", 64'(o_err_code), 64'd0);
    check_eq("rst_num_trans", 64'(o_num_trans), 64'd0);
    rst = 1'b0;
    tick();

    // 1: base configuration
    run_base("t1");

    // 2: channel 0 empty, read batch requested twice
    clear_logs();
    start_run(8'd16, 32'h1000, 32'h2000, 16'd0, 16'd3, 32'h3000, 16'd1);
    check_eq("t2_done_cleared", 64'(o_done), 64'd0);
    tick();
    req_rd();
    wait_rd_done(1, "t2_rd_batch1");
    req_rd();
    wait_rd_done(2, "t2_rd_batch2");
    check_eq("t2_rd_cnt", 64'(rd_addr_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t2_rd_addr%0d", i), 64'(rd_at(i)), 64'(32'h2000 + 32'((i % 3) * 64)));
      check_eq($sformatf("t2_rd_ch%0d", i),
               64'((i < rd_ch_log.size()) ? rd_ch_log[i] : 1'bx), 64'd1);
    end
    req_wr();
    wait_done("t2_run_done");

    // 3: zero beats per burst
    clear_logs();
    start_run(8'd0, 32'h1000, 32'h2000, 16'd2, 16'd2, 32'h3000, 16'd4);
    check_eq("t3_err_early", 64'(o_error), 64'd0);
    tick();
    check_eq("t3_error", 64'(o_error), 64'd1);
    check_eq("t3_code", 64'(o_err_code), 64'd1);
    check_eq("t3_busy", 64'(o_busy), 64'd0);
    tick(); tick(); tick();
    check_eq("t3_no_bursts", 64'(rd_addr_log.size() + wr_addr_log.size()), 64'd0);

    // 4: read done withheld until after the watchdog fires
    clear_logs();
    auto_en = 1'b0;
    start_run(8'd16, 32'h1000, 32'h2000, 16'd1, 16'd0, 32'h3000, 16'd1);
    tick();
    req_rd();
    check_eq("t4_issue", 64'(o_ctrl_read), 64'd1);
    repeat (7) tick();
    check_eq("t4_not_yet", 64'(o_error), 64'd0);
    tick();
    check_eq("t4_error", 64'(o_error), 64'd1);
    check_eq("t4_code", 64'(o_err_code), 64'd2);
    i_read_done = 1'b1;
    tick();
    tick();
    check_eq("t4_late_code", 64'(o_err_code), 64'd2);
    check_eq("t4_late_no_pulse", 64'(n_rd_done), 64'd0);
    check_eq("t4_late_no_issue", 64'(rd_addr_log.size()), 64'd1);
    auto_en = 1'b1;

    // 5: abort in WR_WAIT coinciding with write done
    clear_logs();
    start_run(8'd16, 32'h1000, 32'h2000, 16'd1, 16'd0, 32'h3000, 16'd2);
    tick();
    req_rd();
    wait_rd_done(1, "t5_rd_batch");
    req_wr();
    check_eq("t5_wr_issue", 64'(o_ctrl_write), 64'd1);
    repeat (DMA_LAT) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check_eq("t5_error", 64'(o_error), 64'd1);
    check_eq("t5_code", 64'(o_err_code), 64'd3);
    check_eq("t5_busy", 64'(o_busy), 64'd0);
    tick(); tick(); tick();
    check_eq("t5_no_wr_done", 64'(n_wr_done), 64'd0);
    check_eq("t5_wr_cnt", 64'(wr_addr_log.size()), 64'd1);
    run_base("t5b");

    // 6: simultaneous requests, reset in RD_WAIT, address wrap
    clear_logs();
    start_run(8'd16, 32'h1000, 32'h2000, 16'd2, 16'd2, 32'h3000, 16'd4);
    tick();
    i_req_rd = 1'b1;
    i_req_wr = 1'b1;
    tick();
    i_req_rd = 1'b0;
    i_req_wr = 1'b0;
    check_eq("t6_read_first", 64'(o_ctrl_read), 64'd1);
    check_eq("t6_no_write", 64'(o_ctrl_write), 64'd0);
    tick();
    check_eq("t6_wait_addr", 64'(o_read_addr), 64'h1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    check_eq("t6_rst_busy", 64'(o_busy), 64'd0);
    check_eq("t6_rst_addr", 64'(o_read_addr), 64'd0);
    check_eq("t6_rst_num_trans", 64'(o_num_trans), 64'd0);
    check_eq("t6_rst_misc", 64'({o_ctrl_read, o_ctrl_write, o_core_rd_done, o_core_wr_done,
                                 o_done, o_error, o_err_code, o_rd_ch}), 64'd0);
    check_eq("t6_rst_blk", 64'(o_blk_idx), 64'd0);
    clear_logs();
    start_run(8'd16, 32'hFFFF_FFC0, 32'h2000, 16'd2, 16'd0, 32'h3000, 16'd1);
    tick();
    req_rd();
    wait_rd_done(1, "t6_wrap_batch");
    check_eq("t6_wrap_addr0", 64'(rd_at(0)), 64'hFFFF_FFC0);
    check_eq("t6_wrap_addr1", 64'(rd_at(1)), 64'h0);
    req_wr();
    wait_done("t6_wrap_done");
    check_eq("t6_wrap_wr", 64'(wr_at(0)), 64'h3000);
    check_eq("one_engine_at_a_time", 64'(n_both), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
